// File: rtl/hex_disp_arbiter_if.sv
// hex_disp_arbiter_if
//   Bundles the request/data side and the display side of the HEX display
//   arbiter so sources and the seven-segment path connect through one port.
//   Parameter N_SRC : number of requesters (>= 2).
//   Signals:
//     i_req    [N_SRC]     per-source display request (level)
//     i_data   [24*N_SRC]  source k word at [24k+23:24k], nibble j -> HEXj
//     i_freeze             hold the current owner past dwell expiry
//     o_gnt    [N_SRC]     one-hot grant pulse, data sampled this cycle
//     o_digits [24]        latched display word
//     o_blank  [6]         1 = digit j dark
//     o_owner  [clog2(N)]  index of the source currently shown
//     o_valid              a word has been loaded since reset
//     o_busy               arbiter is in GRANT or DWELL
//   Modports: slave = the arbiter, master = sources / display consumer.
`timescale 1ns/1ps
interface hex_disp_arbiter_if #(
  parameter int N_SRC = 2
);
  localparam int OWN_W = $clog2(N_SRC);

  logic [N_SRC-1:0]    i_req;
  logic [24*N_SRC-1:0] i_data;
  logic                i_freeze;
  logic [N_SRC-1:0]    o_gnt;
  logic [23:0]         o_digits;
  logic [5:0]          o_blank;
  logic [OWN_W-1:0]    o_owner;
  logic                o_valid;
  logic                o_busy;

  modport slave (
    input  i_req, i_data, i_freeze,
    output o_gnt, o_digits, o_blank, o_owner, o_valid, o_busy
  );

  modport master (
    output i_req, i_data, i_freeze,
    input  o_gnt, o_digits, o_blank, o_owner, o_valid, o_busy
  );
endinterface

// File: rtl/hex_disp_arbiter.sv
// hex_disp_arbiter
//   Round-robin scheduler sharing the six-digit HEX display between N_SRC
//   requesters. One requester is granted at a time; its 24-bit word is latched
//   and held for at least DWELL cycles before the arbiter rotates.
//   Parameters:
//     N_SRC : number of requesters (>= 2)
//     DWELL : minimum cycles a granted word stays displayed (>= 1)
//   Ports:
//     i_clk : system clock
//     i_rst : synchronous, active-high reset
//     bus   : hex_disp_arbiter_if.slave (requests, data, freeze, display outputs)
//   Build option:
//     HEX_LEADING_ZERO_BLANK_EN - when defined, each load darkens digits 5..1
//     while they and all higher digits are zero (digit 0 always lit). When
//     undefined, every digit is lit after the first load.
`timescale 1ns/1ps
module hex_disp_arbiter #(
  parameter int N_SRC = 2,
  parameter int DWELL = 25_000_000
) (
  input logic              i_clk,
  input logic              i_rst,
  hex_disp_arbiter_if.slave bus
);

  localparam int OWN_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(DWELL) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  state_t            state;
  logic [OWN_W-1:0]  sel;
  logic [OWN_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [N_SRC-1:0]  gnt_mask;
  logic              busy;
  logic [23:0]       digits;
  logic [5:0]        blank;
  logic [OWN_W-1:0]  owner;
  logic              valid;
  logic [23:0]       sel_word;
  logic [OWN_W-1:0]  pick;

  function automatic logic [OWN_W-1:0] wrap_inc(input logic [OWN_W-1:0] v);
    return (v == OWN_W'(N_SRC - 1)) ? '0 : v + 1'b1;
  endfunction

  // First set request at or above ptr, wrapping modulo N_SRC.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                               input logic [OWN_W-1:0] ptr);
    logic [OWN_W-1:0] idx;
    logic [OWN_W-1:0] res;
    logic             found;
    idx   = ptr;
    res   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return res;
  endfunction

  function automatic logic [N_SRC-1:0] onehot(input logic [OWN_W-1:0] s);
    return N_SRC'(1) << s;
  endfunction

`ifdef HEX_LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit goes dark only while every digit
  // above it (and itself) is zero. Digit 0 is never considered.
  function automatic logic [5:0] lead_zero_blank(input logic [23:0] w);
    logic [5:0] b;
    logic       hi_zero;
    b       = '0;
    hi_zero = 1'b1;
    for (int j = 5; j >= 1; j--) begin
      hi_zero = hi_zero && (w[4*j +: 4] == 4'h0);
      b[j]    = hi_zero;
    end
    return b;
  endfunction
`endif

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel == OWN_W'(k)) sel_word = bus.i_data[24*k +: 24];
    end
  end

  assign pick = rr_pick(bus.i_req, rr_ptr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      sel      <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      gnt_mask <= '0;
      busy     <= 1'b0;
      digits   <= '0;
      blank    <= 6'h3F;
      owner    <= '0;
      valid    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|bus.i_req) begin
            sel      <= pick;
            gnt_mask <= onehot(pick);
            busy     <= 1'b1;
            state    <= ST_GRANT;
          end
        end
        // Grant lasts exactly one cycle; the load only happens if the
        // selected source is still requesting.
        ST_GRANT: begin
          gnt_mask <= '0;
          if (bus.i_req[sel]) begin
            digits <= sel_word;
`ifdef HEX_LEADING_ZERO_BLANK_EN
            blank  <= lead_zero_blank(sel_word);
`else
            blank  <= 6'h00;
`endif
            owner  <= sel;
            valid  <= 1'b1;
            rr_ptr <= wrap_inc(sel);
            cnt    <= CNT_W'(DWELL - 1);
            state  <= ST_DWELL;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_DWELL: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!bus.i_freeze) begin
            if (|bus.i_req) begin
              sel      <= pick;
              gnt_mask <= onehot(pick);
              state    <= ST_GRANT;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          gnt_mask <= '0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // gnt_mask is only nonzero in GRANT; gating with the live request lets a
  // source that withdraws in the grant cycle see no grant.
  assign bus.o_gnt    = gnt_mask & bus.i_req;
  assign bus.o_busy   = busy;
  assign bus.o_digits = digits;
  assign bus.o_blank  = blank;
  assign bus.o_owner  = owner;
  assign bus.o_valid  = valid;

endmodule

// File: tb/tb_hex_disp_arbiter.sv
`timescale 1ns/1ps
module tb_hex_disp_arbiter;
  localparam int N  = 3;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hex_disp_arbiter_if #(.N_SRC(N)) bus();

  hex_disp_arbiter #(.N_SRC(N), .DWELL(DW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    int          src;
    logic [23:0] data;
    logic [5:0]  blank;
  } exp_t;

  typedef struct {
    int          src;
    logic [23:0] data;
    logic [2:0]  gnt;
    logic [5:0]  blank;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       cur;
  bit         pend = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [2:0] last_gnt;
  vec_t       tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int s, input logic [23:0] d, input logic [5:0] b);
    exp_t e;
    e.src = s; e.data = d; e.blank = b;
    exp_q.push_back(e);
  endtask

  task automatic set_lane(input int s, input logic [23:0] d);
    bus.i_data[24*s +: 24] = d;
  endtask

  // Scoreboard: each grant pulse pops the next expected source; the cycle
  // after it the loaded display word is compared.
  task automatic sample();
    cyc++;
    last_gnt = bus.o_gnt;
    if (pend) begin
      chk("sb_digits", 32'(bus.o_digits), 32'(cur.data));
      chk("sb_owner",  32'(bus.o_owner),  32'(cur.src));
      chk("sb_valid",  32'(bus.o_valid),  32'd1);
      chk("sb_blank",  32'(bus.o_blank),  32'(cur.blank));
      pend = 1'b0;
    end
    if (bus.o_gnt != '0) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_gnt", 32'(bus.o_gnt), 32'd0);
      end else begin
        cur = exp_q.pop_front();
        chk("sb_gnt", 32'(bus.o_gnt), 32'(1) << cur.src);
        pend = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    sample();
  endtask

  // Changes i_req just after the edge, before sampling, to act within the
  // cycle that edge started.
  task automatic tick_pre(input logic [2:0] r);
    @(posedge clk);
    #1;
    bus.i_req = r;
    #1;
    sample();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_gnt"},    32'(bus.o_gnt),    32'd0);
    chk({tag, "_digits"}, 32'(bus.o_digits), 32'd0);
    chk({tag, "_blank"},  32'(bus.o_blank),  32'h3F);
    chk({tag, "_valid"},  32'(bus.o_valid),  32'd0);
    chk({tag, "_owner"},  32'(bus.o_owner),  32'd0);
    chk({tag, "_busy"},   32'(bus.o_busy),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcount;
    int gseen;
    int gcyc[4];

    tbl[0] = '{src: 1, data: 24'h123456, gnt: 3'b010, blank: 6'h00};
    tbl[1] = '{src: 0, data: 24'h000405, gnt: 3'b001, blank: 6'h00};
    tbl[2] = '{src: 2, data: 24'h000000, gnt: 3'b100, blank: 6'h00};
    tbl[3] = '{src: 1, data: 24'h100000, gnt: 3'b010, blank: 6'h00};
    tbl[4] = '{src: 0, data: 24'h0A0000, gnt: 3'b001, blank: 6'h00};
    tbl[5] = '{src: 2, data: 24'h00000F, gnt: 3'b100, blank: 6'h00};
`ifdef HEX_LEADING_ZERO_BLANK_EN
    tbl[1].blank = 6'b111000;
    tbl[2].blank = 6'b111110;
    tbl[4].blank = 6'b100000;
    tbl[5].blank = 6'b111110;
`endif

    // Reset held with every source requesting
    rst          = 1'b1;
    bus.i_req    = 3'b111;
    bus.i_freeze = 1'b0;
    bus.i_data   = {24'h333333, 24'h222222, 24'h111111};
    repeat (2) begin
      tick();
      check_reset_vals("rst_hold");
    end
    rst       = 1'b0;
    bus.i_req = 3'b000;
    tick();

    // Single-source requests from the table
    for (int i = 0; i < 6; i++) begin
      bus.i_req = tbl[i].gnt;
      set_lane(tbl[i].src, tbl[i].data);
      push_exp(tbl[i].src, tbl[i].data, tbl[i].blank);
      tick();
      chk("vec_gnt_latency", 32'(last_gnt), 32'(tbl[i].gnt));
      tick();
      bus.i_req = 3'b000;
      repeat (3) tick();
      chk("vec_dwell_busy", 32'(bus.o_busy), 32'd1);
      tick();
      chk("vec_idle_busy", 32'(bus.o_busy), 32'd0);
    end

    // All sources requesting: served 0,1,2,0 with DWELL+1 spacing
    set_lane(0, 24'h900000);
    set_lane(1, 24'h911111);
    set_lane(2, 24'h922222);
    bus.i_req = 3'b111;
    push_exp(0, 24'h900000, 6'h00);
    push_exp(1, 24'h911111, 6'h00);
    push_exp(2, 24'h922222, 6'h00);
    push_exp(0, 24'h900000, 6'h00);
    gcount = 0;
    for (int k = 0; k < 40 && gcount < 4; k++) begin
      tick();
      if (last_gnt != 3'b000) begin
        gcyc[gcount] = cyc;
        gcount++;
      end
    end
    chk("rot_grant_count", 32'(gcount), 32'd4);
    for (int j = 1; j < 4; j++) begin
      if (j < gcount) chk("rot_spacing", 32'(gcyc[j] - gcyc[j-1]), 32'(DW + 1));
    end
    tick();
    bus.i_req = 3'b000;
    repeat (4) tick();

    // Freeze during dwell while another source waits, then reset mid-dwell
    set_lane(1, 24'h955555);
    bus.i_req = 3'b010;
    push_exp(1, 24'h955555, 6'h00);
    tick();
    set_lane(2, 24'h966666);
    bus.i_req = 3'b110;
    push_exp(2, 24'h966666, 6'h00);
    tick();
    bus.i_req = 3'b100;
    tick();
    bus.i_freeze = 1'b1;
    gseen = 0;
    repeat (10) begin
      tick();
      if (last_gnt != 3'b000) gseen++;
    end
    chk("freeze_no_gnt", 32'(gseen), 32'd0);
    bus.i_freeze = 1'b0;
    tick();
    chk("freeze_release_gnt", 32'(last_gnt), 32'b100);
    tick();
    bus.i_req = 3'b000;
    tick();
    chk("mid_dwell_busy", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_vals("rst_mid_dwell");
    rst = 1'b0;
    tick();

    // Withdraw in the grant cycle; pointer must stay where the last load left it
    set_lane(0, 24'h988888);
    bus.i_req = 3'b001;
    push_exp(0, 24'h988888, 6'h00);
    tick();
    tick();
    bus.i_req = 3'b000;
    repeat (4) tick();
    set_lane(2, 24'h977777);
    bus.i_req = 3'b100;
    tick_pre(3'b000);
    chk("wd_gnt", 32'(last_gnt), 32'd0);
    chk("wd_busy_in_grant", 32'(bus.o_busy), 32'd1);
    tick();
    chk("wd_digits_kept", 32'(bus.o_digits), 32'h988888);
    chk("wd_owner_kept", 32'(bus.o_owner), 32'd0);
    chk("wd_idle_busy", 32'(bus.o_busy), 32'd0);
    set_lane(1, 24'h944444);
    bus.i_req = 3'b011;
    push_exp(1, 24'h944444, 6'h00);
    tick();
    chk("wd_next_gnt", 32'(last_gnt), 32'b010);
    tick();
    bus.i_req = 3'b000;
    repeat (4) tick();

    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
